// File: rtl/imu_frame_sched.sv
// IMU angle-frame scheduler: parses 0x55/0x53 serial frames, then converts the
// X/Y/Z angle words to BCD degrees on one shared converter.
module imu_frame_sched #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_int,
  input  logic [7:0] rx_data,
  output logic [3:0] angle_x_b,
  output logic [3:0] angle_x_s,
  output logic [3:0] angle_x_g,
  output logic [3:0] angle_y_b,
  output logic [3:0] angle_y_s,
  output logic [3:0] angle_y_g,
  output logic [3:0] angle_z_b,
  output logic [3:0] angle_z_s,
  output logic [3:0] angle_z_g,
  output logic       sign_x,
  output logic       sign_y,
  output logic       sign_z,
  output logic       frame_ok,
  output logic       upd,
  output logic       busy,
  output logic [7:0] err_cnt
);

  // parser   state | meaning
  //   HUNT  | waiting for 0x55 header
  //   TYPE  | next byte is the frame type
  //   DATA  | collecting D0..D7
  //   SUM   | next byte is the checksum
  // converter state | meaning
  //   C_IDLE  | no conversion running
  //   C_LOAD  | magnitude and degree scaling of current axis
  //   C_SHIFT | double-dabble, one bit per cycle
  //   C_STORE | digits to shadow (or to outputs after Z)
  typedef enum logic [1:0] {HUNT, TYPE, DATA, SUM} pstate_t;
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT, C_STORE} cstate_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic rx_s1, rx_s2, rx_s3, acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_s3 <= 1'b0;
    end else begin
      rx_s1 <= rx_int;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign acc = rx_s3 & ~rx_s2;

  pstate_t ps, ps_nx;
  logic [2:0]    idx;
  logic [7:0]    typ, csum;
  logic [7:0]    dbuf [6];
  logic [TW-1:0] tmr;
  logic [15:0]   pend_x, pend_y, pend_z;
  logic          tmo, sum_acc, good, bad;

  assign tmo     = (ps != HUNT) && !acc && (tmr == '0);
  assign sum_acc = acc && (ps == SUM);
  assign good    = sum_acc && (rx_data == csum) && (typ == 8'h53);
  assign bad     = sum_acc && (rx_data != csum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ps <= HUNT;
    else      ps <= ps_nx;
  end

  always_comb begin
    ps_nx = ps;
    if (tmo) begin
      ps_nx = HUNT;
    end else if (acc) begin
      case (ps)
        HUNT:    if (rx_data == 8'h55) ps_nx = TYPE;
        TYPE:    ps_nx = DATA;
        DATA:    if (idx == 3'd7) ps_nx = SUM;
        default: ps_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      typ      <= '0;
      csum     <= '0;
      tmr      <= '0;
      pend_x   <= '0;
      pend_y   <= '0;
      pend_z   <= '0;
      frame_ok <= 1'b0;
      err_cnt  <= '0;
      for (int i = 0; i < 6; i++) dbuf[i] <= '0;
    end else begin
      frame_ok <= good;
      if (acc) tmr <= TW'(TIMEOUT_CYC - 1);
      else if (ps != HUNT && tmr != '0) tmr <= tmr - 1'b1;
      if (acc) begin
        case (ps)
          HUNT: csum <= rx_data;
          TYPE: begin
            typ  <= rx_data;
            csum <= csum + rx_data;
            idx  <= '0;
          end
          DATA: begin
            if (idx < 3'd6) dbuf[idx] <= rx_data;
            csum <= csum + rx_data;
            idx  <= idx + 1'b1;
          end
          default: ;
        endcase
      end
      if (good) begin
        pend_x <= {dbuf[1], dbuf[0]};
        pend_y <= {dbuf[3], dbuf[2]};
        pend_z <= {dbuf[5], dbuf[4]};
      end
      if ((bad || tmo) && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  cstate_t cs, cs_nx;
  logic [1:0]  ax;
  logic [3:0]  cnt;
  logic        pend, start, sgn_cur;
  logic [15:0] snap_x, snap_y, snap_z, raw;
  logic [16:0] mag;
  logic [23:0] prod;
  logic [8:0]  deg, bin;
  logic [11:0] bcd, bcd_adj, sh_x, sh_y, out_x, out_y, out_z;
  logic        sh_sx, sh_sy;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign start   = (cs == C_IDLE) && (frame_ok || pend);
  assign busy    = (cs != C_IDLE);
  assign mag     = raw[15] ? (17'h10000 - {1'b0, raw}) : {1'b0, raw};
  assign prod    = {7'd0, mag} * 24'd180;
  assign deg     = 9'(prod >> 15);
  assign bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};

  always_comb begin
    case (ax)
      2'd1:    raw = snap_y;
      2'd2:    raw = snap_z;
      default: raw = snap_x;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cs <= C_IDLE;
    else      cs <= cs_nx;
  end

  always_comb begin
    cs_nx = cs;
    case (cs)
      C_IDLE:  if (start) cs_nx = C_LOAD;
      C_LOAD:  cs_nx = C_SHIFT;
      C_SHIFT: if (cnt == 4'd0) cs_nx = C_STORE;
      default: cs_nx = (ax == 2'd2) ? C_IDLE : C_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= 1'b0;
      ax      <= '0;
      cnt     <= '0;
      snap_x  <= '0;
      snap_y  <= '0;
      snap_z  <= '0;
      bin     <= '0;
      bcd     <= '0;
      sgn_cur <= 1'b0;
      sh_x    <= '0;
      sh_y    <= '0;
      sh_sx   <= 1'b0;
      sh_sy   <= 1'b0;
      out_x   <= '0;
      out_y   <= '0;
      out_z   <= '0;
      sign_x  <= 1'b0;
      sign_y  <= 1'b0;
      sign_z  <= 1'b0;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (start)         pend <= 1'b0;
      else if (frame_ok) pend <= 1'b1;
      case (cs)
        C_IDLE: if (start) begin
          snap_x <= pend_x;
          snap_y <= pend_y;
          snap_z <= pend_z;
          ax     <= '0;
        end
        C_LOAD: begin
          bin     <= deg;
          bcd     <= '0;
          sgn_cur <= raw[15];
          cnt     <= 4'd8;
        end
        C_SHIFT: begin
          bcd <= 12'({bcd_adj, bin[8]});
          bin <= {bin[7:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        default: begin
          case (ax)
            2'd0: begin sh_x <= bcd; sh_sx <= sgn_cur; end
            2'd1: begin sh_y <= bcd; sh_sy <= sgn_cur; end
            default: begin
              // Z goes straight out together with the X/Y shadows
              out_x  <= sh_x;
              out_y  <= sh_y;
              out_z  <= bcd;
              sign_x <= sh_sx;
              sign_y <= sh_sy;
              sign_z <= sgn_cur;
              upd    <= 1'b1;
            end
          endcase
          ax <= ax + 1'b1;
        end
      endcase
    end
  end

  assign {angle_x_b, angle_x_s, angle_x_g} = out_x;
  assign {angle_y_b, angle_y_s, angle_y_g} = out_y;
  assign {angle_z_b, angle_z_s, angle_z_g} = out_z;

endmodule

// File: tb/tb_imu_frame_sched.sv
// Directed bench for imu_frame_sched: frame decode, latency, pending overlap,
// checksum/timeout errors, reset abort and error-counter saturation.
module tb_imu_frame_sched;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_int = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] axb, axs, axg, ayb, ays, ayg, azb, azs, azg;
  logic       sign_x, sign_y, sign_z, frame_ok, upd, busy;
  logic [7:0] err_cnt;

  imu_frame_sched #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_int(rx_int), .rx_data(rx_data),
    .angle_x_b(axb), .angle_x_s(axs), .angle_x_g(axg),
    .angle_y_b(ayb), .angle_y_s(ays), .angle_y_g(ayg),
    .angle_z_b(azb), .angle_z_s(azs), .angle_z_g(azg),
    .sign_x(sign_x), .sign_y(sign_y), .sign_z(sign_z),
    .frame_ok(frame_ok), .upd(upd), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [38:0] A_VEC = {1'b0, 12'h090, 1'b1, 12'h180, 1'b1, 12'h000};
  localparam logic [38:0] C_VEC = {1'b1, 12'h090, 1'b0, 12'h045, 1'b0, 12'h135};
  localparam logic [38:0] D_VEC = {1'b0, 12'h179, 1'b0, 12'h000, 1'b0, 12'h000};

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int fok_cnt = 0, upd_cnt = 0, run = 0, last_run = 0;
  int fok_cyc [16];
  int fok_busy [16];
  int upd_cyc [16];
  logic [38:0] upd_log [16];
  logic [7:0] fa [11], fb [11], fc [11], fd [11], ft [11];

  wire [38:0] out_vec = {sign_x, axb, axs, axg, sign_y, ayb, ays, ayg, sign_z, azb, azs, azg};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_ok) begin
      fok_cyc[fok_cnt % 16]  = cyc;
      fok_busy[fok_cnt % 16] = int'(busy);
      fok_cnt++;
    end
    if (upd) begin
      upd_cyc[upd_cnt % 16] = cyc;
      upd_log[upd_cnt % 16] = out_vec;
      upd_cnt++;
    end
    if (busy) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_int  = 1'b0;
    @(negedge clk);
    rx_int  = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s [11], input int n);
    for (int i = 0; i < n; i++) send_byte(s[i]);
  endtask

  task automatic build(input logic [7:0] typ, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic [7:0] sum_xor,
                       output logic [7:0] f [11]);
    logic [7:0] s;
    f = '{8'h55, typ, x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8], 8'h00, 8'h00, 8'h00};
    s = 8'h00;
    for (int i = 0; i < 10; i++) s = s + f[i];
    f[10] = s ^ sum_xor;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    int k;
    fa = '{8'h55, 8'h53, 8'h00, 8'h40, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h66};
    fb = fa;
    fb[10] = 8'h67;
    build(8'h53, 16'hC000, 16'h2000, 16'h6000, 8'h00, fc);
    build(8'h53, 16'h7FFF, 16'h0000, 16'h0000, 8'h00, fd);
    build(8'h51, 16'h1234, 16'h5678, 16'h9ABC, 8'h00, ft);

    wait_cyc(3);
    chk("rst_out", out_vec, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_flags", {busy, upd, frame_ok}, 0);
    @(negedge clk) rst = 1'b1;
    wait_cyc(3);

    // basic decode and latency
    send_seq(fa, 11);
    wait_cyc(60);
    chk("a_fok", fok_cnt, 1);
    chk("a_upd", upd_cnt, 1);
    chk("a_latency", upd_cyc[0] - fok_cyc[0], 34);
    chk("a_busy_len", last_run, 33);
    chk("a_at_upd", upd_log[0], A_VEC);
    chk("a_err", err_cnt, 0);

    // bad checksum
    send_seq(fb, 11);
    wait_cyc(60);
    chk("bad_fok", fok_cnt, 1);
    chk("bad_upd", upd_cnt, 1);
    chk("bad_err", err_cnt, 1);
    chk("bad_out_hold", out_vec, A_VEC);

    // junk then resync; 2nd 0x55 becomes TYPE and swallows one frame
    send_byte(8'h12);
    send_byte(8'h55);
    send_byte(8'h55);
    send_seq(fd, 11);
    wait_cyc(5);
    chk("junk_err", err_cnt, 2);
    chk("junk_fok", fok_cnt, 1);
    send_seq(fd, 11);
    wait_cyc(60);
    chk("d_fok", fok_cnt, 2);
    chk("d_out", out_vec, D_VEC);

    // back-to-back frames, second lands while busy
    send_seq(fa, 11);
    send_seq(fc, 11);
    wait_cyc(80);
    chk("ovl_upd", upd_cnt, 4);
    chk("ovl_fok_busy", fok_busy[3], 1);
    chk("ovl_first", upd_log[2], A_VEC);
    chk("ovl_second", upd_log[3], C_VEC);
    chk("ovl_lat1", upd_cyc[2] - fok_cyc[2], 34);
    chk("ovl_gap", upd_cyc[3] - upd_cyc[2], 34);

    // inter-byte timeout after D3
    send_seq(fa, 6);
    wait_cyc(TMO + 10);
    chk("tmo_err", err_cnt, 3);
    chk("tmo_fok", fok_cnt, 4);
    send_seq(fa, 11);
    wait_cyc(60);
    chk("tmo_next_fok", fok_cnt, 5);
    chk("tmo_next_out", out_vec, A_VEC);

    // other frame type with valid sum
    send_seq(ft, 11);
    wait_cyc(60);
    chk("t51_fok", fok_cnt, 5);
    chk("t51_upd", upd_cnt, 5);
    chk("t51_err", err_cnt, 3);

    // reset mid-conversion
    send_seq(fc, 11);
    k = 0;
    while (fok_cnt < 6 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("r_fok", fok_cnt, 6);
    wait_cyc(10);
    chk("r_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("r_out", out_vec, 0);
    chk("r_err", err_cnt, 0);
    chk("r_busy", busy, 0);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(60);
    chk("r_no_upd", upd_cnt, 5);
    send_seq(fa, 11);
    wait_cyc(60);
    chk("r_next_upd", upd_cnt, 6);
    chk("r_next_out", out_vec, A_VEC);

    // error counter saturation
    for (int i = 0; i < 300; i++) send_seq(fb, 11);
    wait_cyc(5);
    chk("sat_err", err_cnt, 255);
    chk("sat_fok", fok_cnt, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imu_frame_sched.md
IMU_FRAME_SCHED -- requirements
Module: imu_frame_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, mid-frame inter-byte timeout in clk cycles.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx_int  input  1  UART byte-done strobe, asynchronous to clk; a falling edge marks a new byte.
REQ-005 SHALL have port rx_data  input  8  received byte, stable from rx_int fall until the next rx_int rise.
REQ-006 SHALL have ports angle_x_b/_s/_g, angle_y_b/_s/_g, angle_z_b/_s/_g  output  4 each  BCD hundreds/tens/units of axis magnitude in degrees.
REQ-007 SHALL have ports sign_x, sign_y, sign_z  output  1 each  raw bit 15 of the axis word.
REQ-008 SHALL have port frame_ok  output  1  one-cycle pulse when a checksum-valid 0x53 frame is latched.
REQ-009 SHALL have port upd  output  1  one-cycle pulse when all angle/sign outputs update together.
REQ-010 SHALL have port busy  output  1  high while the shared converter is running.
REQ-011 SHALL have port err_cnt  output  8  saturating count of checksum failures and timeouts.

Function
REQ-012 rx_int SHALL pass a 2-FF synchronizer; a byte is accepted in the cycle its synchronized falling edge is detected, sampling rx_data then.
REQ-013 Parser FSM SHALL have states HUNT, TYPE, DATA (8 bytes D0..D7), SUM.
REQ-014 HUNT: 0x55 -> TYPE; any other byte is discarded.
REQ-015 TYPE: any byte is stored as type -> DATA with byte index 0.
REQ-016 DATA: byte stored at index; after D7 -> SUM. 0x55 inside DATA is plain data.
REQ-017 SUM: byte compared to the low 8 bits of the sum of the 10 preceding bytes (header through D7); the FSM returns to HUNT in every case.
REQ-018 Match with type 0x53: raw X={D1,D0}, Y={D3,D2}, Z={D5,D4} SHALL be latched into the pending registers; frame_ok pulses the next cycle. D6/D7 (temperature) are ignored.
REQ-019 Match with any other type: the frame SHALL be dropped with no error and no pulse.
REQ-020 Mismatch: the frame SHALL be dropped and err_cnt incremented, saturating at 255.
REQ-021 A timer SHALL reset on each accepted byte; in any state other than HUNT, TIMEOUT_CYC cycles without a byte SHALL force HUNT and increment err_cnt.
REQ-022 Converter SHALL be a single shared unit sequencing X, Y, Z. Each axis takes LOAD (1 cycle), SHIFT (9 cycles), STORE (1 cycle).
REQ-023 LOAD: m = raw[15] ? (65536 - raw) : raw (17-bit; 0x8000 gives 32768); deg = (m*180)>>15, 9 bits, range 0..180.
REQ-024 SHIFT: double-dabble deg into 3 BCD digits, one bit per cycle (add 3 to any digit >=5 before each shift).
REQ-025 STORE: digits and sign SHALL go to shadow registers; visible outputs SHALL not change during conversion.
REQ-026 Converter SHALL start in the cycle after frame_ok when idle. busy SHALL go high that cycle and stay high for 33 cycles.
REQ-027 In the cycle after the Z STORE, shadow SHALL copy to outputs and upd SHALL pulse; upd SHALL occur 34 cycles after the frame_ok cycle.
REQ-028 A good 0x53 frame arriving while busy SHALL overwrite the pending registers and set a pending flag; frames latched earlier in the same conversion are lost, newest wins.
REQ-029 The conversion in progress SHALL use the snapshot taken at its start, unaffected by pending writes.
REQ-030 If pending is set when a conversion completes, the next conversion SHALL start in the cycle after upd and clear pending.
REQ-031 Parser and converter SHALL run concurrently; byte acceptance never stalls.

Reset
REQ-032 rst low SHALL asynchronously clear all outputs to 0, set the parser to HUNT, idle the converter, and clear pending, timer, and synchronizer.
REQ-033 Reset mid-frame or mid-conversion SHALL abort with no upd; the first frame after release SHALL be parsed from HUNT.

Verification
REQ-034 Frame 55 53 00 40 00 80 FF FF 00 00 66 -> frame_ok; upd 34 cycles later; X=0,9,0 sign 0; Y=1,8,0 sign 1; Z=0,0,0 sign 1.
REQ-035 Same frame with SUM=0x67 -> no frame_ok, no upd, err_cnt 0->1; outputs unchanged.
REQ-036 X raw 0x7FFF (FF 7F), valid SUM -> X=1,7,9 sign 0. Junk bytes 12 55 55 before a frame -> resync; the 2nd 0x55 is taken as TYPE and that frame is dropped; the following clean frame is decoded correctly.
REQ-037 Two valid 0x53 frames, the second ending while busy -> two upd pulses; the second reflects the second frame and starts in the cycle after the first upd.
REQ-038 Stop after D3 for TIMEOUT_CYC cycles -> HUNT, err_cnt+1; the next full frame decodes. Assert rst mid-conversion -> all outputs 0, no upd.
REQ-039 Type 0x51 frame with a valid SUM -> no pulse, err_cnt unchanged. Feed 300 bad frames -> err_cnt holds at 255.
